cache_burst_controller: RTL and testbench

CACHE_BURST_CONTROLLER -- requirements
Module: cache_burst_controller

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_burst_controller_if.sv | 48 ++++
 rtl/cache_beat_counter.sv | 37 +++
 rtl/cache_burst_controller.sv | 158 +++++++++++++++
 tb/tb_cache_burst_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache burst controller.
//   cc_state_t             : controller FSM states
//   REQ_READ / REQ_WRITE   : encodings of req_type
//   DEFAULT_WORDS_PER_LINE : default number of beats per cache line
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB_CMD,
    WB_DATA,
    RF_CMD,
    RF_DATA,
    REFILL_DONE
  } cc_state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam int unsigned DEFAULT_WORDS_PER_LINE = 4;

endpackage

// File: rtl/cache_burst_controller_if.sv
// Bus bundle between the cache burst controller and its environment.
// Signals:
//   CPU side    : req_valid, req_ready, req_type, hit, dirty_bit
//   Memory side : mem_cmd_valid/ready/write, mem_wvalid/wready, mem_rvalid/rready
//   Data array  : beat_idx, read_en_cache, write_en_cache, refill, done_cache
//   Perf        : hit_count, miss_count
// Modports:
//   master : the controller (drives control/status outputs)
//   slave  : the CPU, tag array and memory model around it
interface cache_burst_controller_if import cache_pkg::*; #(
  parameter int unsigned WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int unsigned CNT_W          = 32
);
  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);

  logic              req_valid;
  logic              req_ready;
  logic              req_type;
  logic              hit;
  logic              dirty_bit;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_write;
  logic              mem_wvalid;
  logic              mem_wready;
  logic              mem_rvalid;
  logic              mem_rready;
  logic [BEAT_W-1:0] beat_idx;
  logic              read_en_cache;
  logic              write_en_cache;
  logic              refill;
  logic              done_cache;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  req_valid, req_type, hit, dirty_bit, mem_cmd_ready, mem_wready, mem_rvalid,
    output req_ready, mem_cmd_valid, mem_cmd_write, mem_wvalid, mem_rready, beat_idx,
           read_en_cache, write_en_cache, refill, done_cache, hit_count, miss_count
  );

  modport slave (
    output req_valid, req_type, hit, dirty_bit, mem_cmd_ready, mem_wready, mem_rvalid,
    input  req_ready, mem_cmd_valid, mem_cmd_write, mem_wvalid, mem_rready, beat_idx,
           read_en_cache, write_en_cache, refill, done_cache, hit_count, miss_count
  );

endinterface

// File: rtl/cache_beat_counter.sv
// Beat counter for line bursts. Counts modulo WORDS_PER_LINE (a power of two).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_clear  : synchronous clear to 0 (wins over i_incr)
//   i_incr   : advance by one beat
//   o_count  : current beat index
//   o_last   : current beat is WORDS_PER_LINE-1
module cache_beat_counter #(
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_clear,
  input  logic                              i_incr,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_count,
  output logic                              o_last
);
  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(WORDS_PER_LINE - 1);

  logic [BEAT_W-1:0] r_count;

  // Power-of-two line length, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LastBeat);

endmodule

// File: rtl/cache_burst_controller.sv
// Cache miss/burst controller: on each accepted CPU request it checks the tag
// result, completes hits in place, and on a miss optionally writes back the dirty
// victim line then refills the line from memory, one beat per handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_burst_controller_if.master (CPU, memory and data-array signals)
// Build option: define CACHE_PERF_CNT_EN to enable saturating hit/miss counters;
// otherwise hit_count/miss_count are constant 0.
module cache_burst_controller import cache_pkg::*; #(
  parameter int unsigned WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  cache_burst_controller_if.master  bus
);
  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);

  cc_state_t         r_state;
  cc_state_t         w_state_next;
  logic              r_req_type_q;
  logic              w_accept;
  logic              w_cnt_clear;
  logic              w_cnt_incr;
  logic              w_cnt_last;
  logic [BEAT_W-1:0] w_cnt;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_type_q <= REQ_READ;
    end else if (w_accept) begin
      r_req_type_q <= bus.req_type;
    end
  end

  cache_beat_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_beat_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_cnt_clear),
    .i_incr (w_cnt_incr),
    .o_count(w_cnt),
    .o_last (w_cnt_last)
  );

  always_comb begin
    w_state_next       = r_state;
    w_cnt_clear        = 1'b0;
    w_cnt_incr         = 1'b0;
    bus.req_ready      = 1'b0;
    bus.mem_cmd_valid  = 1'b0;
    bus.mem_cmd_write  = 1'b0;
    bus.mem_wvalid     = 1'b0;
    bus.mem_rready     = 1'b0;
    bus.beat_idx       = '0;
    bus.read_en_cache  = 1'b0;
    bus.write_en_cache = 1'b0;
    bus.refill         = 1'b0;
    bus.done_cache     = 1'b0;

    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_next = COMPARE;
      end
      COMPARE: begin
        if (bus.hit) begin
          bus.done_cache     = 1'b1;
          bus.write_en_cache = r_req_type_q;
          bus.read_en_cache  = ~r_req_type_q;
          w_state_next       = IDLE;
        end else begin
          w_state_next = bus.dirty_bit ? WB_CMD : RF_CMD;
        end
      end
      WB_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_write = 1'b1;
        if (bus.mem_cmd_ready) begin
          w_cnt_clear  = 1'b1;
          w_state_next = WB_DATA;
        end
      end
      WB_DATA: begin
        bus.mem_wvalid    = 1'b1;
        bus.read_en_cache = 1'b1;
        bus.beat_idx      = w_cnt;
        if (bus.mem_wready) begin
          w_cnt_incr = 1'b1;
          if (w_cnt_last) w_state_next = RF_CMD;
        end
      end
      RF_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        if (bus.mem_cmd_ready) begin
          w_cnt_clear  = 1'b1;
          w_state_next = RF_DATA;
        end
      end
      RF_DATA: begin
        bus.mem_rready = 1'b1;
        bus.beat_idx   = w_cnt;
        if (bus.mem_rvalid) begin
          bus.write_en_cache = 1'b1;
          w_cnt_incr         = 1'b1;
          if (w_cnt_last) w_state_next = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        // Line is now resident: finish the original access against it.
        bus.refill         = 1'b1;
        bus.done_cache     = 1'b1;
        bus.write_en_cache = r_req_type_q;
        bus.read_en_cache  = ~r_req_type_q;
        w_state_next       = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic             w_hit_evt;
  logic             w_miss_evt;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  assign w_hit_evt  = (r_state == COMPARE) && bus.hit;
  assign w_miss_evt = (r_state == COMPARE) && !bus.hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_evt && (r_hit_count != '1))   r_hit_count  <= r_hit_count + 1'b1;
      if (w_miss_evt && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_burst_controller.sv
// Scoreboard bench for cache_burst_controller: the driver pushes the expected event
// stream of each request (memory commands, beats, completion) into a queue; the
// monitor pops and compares whenever the DUT shows a handshake or done_cache.
module tb_cache_burst_controller;
  import cache_pkg::*;

  localparam int unsigned WPL     = 4;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Event kinds: 0 mem command, 1 write-back beat, 2 refill beat, 3 completion.
  typedef struct {
    int kind;
    int val;
    int lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  ev_t  exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  int   acc_cyc    = 0;
  int   done_cnt   = 0;
  int   mode       = 1;  // 0 random stalls, 1 never stall, 3 stall write-back beat 2
  int   stall_left = 0;
  int   exp_hit    = 0;
  int   exp_miss   = 0;

  cache_burst_controller_if #(.WORDS_PER_LINE(WPL), .CNT_W(CW)) bus ();

  cache_burst_controller #(
    .WORDS_PER_LINE(WPL),
    .CNT_W         (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val, input int lat);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic got(input string name, input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: unexpected event value %0d, expected no event (t=%0t)", name, val,
               $time);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk(name, val, e.val);
      if (e.lat >= 0) chk("latency", cyc - acc_cyc + 2, e.lat);
    end
  endtask

  // Memory responder.
  initial begin
    bit stalling;
    stalling          = 1'b0;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_wready    = 1'b0;
    bus.mem_rvalid    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) begin
        bus.mem_cmd_ready = ($urandom % 3) != 0;
        bus.mem_wready    = ($urandom % 3) != 0;
        bus.mem_rvalid    = ($urandom % 3) != 0;
      end else begin
        bus.mem_cmd_ready = 1'b1;
        bus.mem_rvalid    = 1'b1;
        bus.mem_wready    = 1'b1;
        if (mode == 3) begin
          if (stalling) begin
            chk("wb_hold_wvalid", int'(bus.mem_wvalid), 1);
            chk("wb_hold_idx", int'(bus.beat_idx), 2);
          end
          stalling = 1'b0;
          if (stall_left > 0 && bus.mem_wvalid && bus.beat_idx == 2) begin
            bus.mem_wready = 1'b0;
            stall_left--;
            stalling = 1'b1;
          end
        end
      end
    end
  end

  // Monitor.
  initial begin
    logic [8:0] idle_outs;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_cmd_valid && bus.mem_cmd_ready) got("mem_cmd", 0, int'(bus.mem_cmd_write));
        if (bus.mem_wvalid && bus.mem_wready)
          got("wb_beat", 1, int'(bus.beat_idx) + 256 * int'(bus.read_en_cache));
        if (bus.mem_rready && bus.mem_rvalid)
          got("rf_beat", 2, int'(bus.beat_idx) + 256 * int'(bus.write_en_cache));
        if (bus.done_cache) begin
          got("done", 3, 4 * int'(bus.refill) + 2 * int'(bus.write_en_cache)
                         + int'(bus.read_en_cache));
          done_cnt++;
        end
        if (!bus.mem_wvalid && !bus.mem_rready) chk("beat_idx_outside", int'(bus.beat_idx), 0);
        if (bus.req_ready) begin
          idle_outs = {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_wvalid, bus.mem_rready,
                       bus.read_en_cache, bus.write_en_cache, bus.refill, bus.done_cache,
                       (bus.beat_idx != 0)};
          chk("idle_outputs", int'(idle_outs), 0);
        end
      end
    end
  end

  // One CPU request; lat is the expected acceptance-to-done latency or -1.
  task automatic txn(input bit t, input bit h, input bit d, input int lat);
    int d0;
    int n;
    if (h) begin
      push(3, 2 * int'(t) + int'(!t), lat);
      if (PERF && exp_hit < CNT_MAX) exp_hit++;
    end else begin
      if (d) begin
        push(0, 1, -1);
        for (int b = 0; b < WPL; b++) push(1, 256 + b, -1);
      end
      push(0, 0, -1);
      for (int b = 0; b < WPL; b++) push(2, 256 + b, -1);
      push(3, 4 + 2 * int'(t) + int'(!t), lat);
      if (PERF && exp_miss < CNT_MAX) exp_miss++;
    end
    d0            = done_cnt;
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.hit       = h;
    bus.dirty_bit = d;
    chk("req_ready_idle", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
    bus.req_type  = 1'($urandom);
    @(posedge clk);
    #1;
    // Tag inputs are only meaningful in the compare cycle.
    bus.hit       = 1'($urandom);
    bus.dirty_bit = 1'($urandom);
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_timeout", int'(done_cnt != d0), 1);
    chk("hit_count", int'(bus.hit_count), exp_hit);
    chk("miss_count", int'(bus.miss_count), exp_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] outs;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_type  = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty_bit = 1'b0;
    #2;
    outs = {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_wvalid, bus.mem_rready,
            bus.read_en_cache, bus.write_en_cache, bus.refill, bus.done_cache,
            (bus.beat_idx != 0)};
    chk("reset_req_ready", int'(bus.req_ready), 1);
    chk("reset_outputs", int'(outs), 0);
    chk("reset_hit_count", int'(bus.hit_count), 0);
    chk("reset_miss_count", int'(bus.miss_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-stall directed cases with latency.
    mode = 1;
    txn(REQ_READ, 1'b1, 1'b0, 2);
    txn(REQ_WRITE, 1'b0, 1'b0, 4 + WPL);
    txn(REQ_READ, 1'b0, 1'b1, 5 + 2 * WPL);

    // Write-back stalled for three cycles on beat 2.
    mode       = 3;
    stall_left = 3;
    txn(REQ_WRITE, 1'b0, 1'b1, 8 + 2 * WPL);
    chk("wb_stall_applied", stall_left, 0);
    mode = 1;

    // Reset in the middle of a refill, at beat 1.
    push(0, 0, -1);
    push(2, 256, -1);
    push(2, 257, -1);
    bus.req_valid = 1'b1;
    bus.req_type  = REQ_READ;
    bus.hit       = 1'b0;
    bus.dirty_bit = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.mem_rready && bus.beat_idx == 1) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_rf_beat1", int'(n < 50), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", int'(bus.req_ready), 1);
    chk("midrst_rready", int'(bus.mem_rready), 0);
    chk("midrst_beat_idx", int'(bus.beat_idx), 0);
    chk("midrst_write_en", int'(bus.write_en_cache), 0);
    @(posedge clk);
    #1;
    chk("postrst_req_ready", int'(bus.req_ready), 1);
    chk("postrst_cmd_valid", int'(bus.mem_cmd_valid), 0);
    rst      = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    chk("postrst_queue_empty", exp_q.size(), 0);
    chk("postrst_hit_count", int'(bus.hit_count), 0);
    txn(REQ_READ, 1'b1, 1'b0, 2);

    // Counter saturation.
    for (int i = 0; i < 20; i++) txn(REQ_READ, 1'b1, 1'b0, 2);
    chk("hit_count_saturated", int'(bus.hit_count), PERF ? CNT_MAX : 0);

    // Random traffic with random memory stalls.
    mode = 0;
    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom), ($urandom % 2) == 0, 1'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
